// File: rtl/hex_display_scan_ctrl.sv
// hex_to_7seg: combinational hex-to-seven-segment decoder, active-low.
//   digit : 4-bit hex value
//   seg   : segments, seg[0]=a .. seg[6]=g, 0 = lit
//
// hex_display_scan_ctrl: shares one hex_to_7seg among NUM_DIGITS digits.
// A load strobe captures a multi-digit value; the digits are scanned from
// the most significant down, one per clock, applying leading-zero blanking
// and an optional minus sign. The full set of patterns is then committed
// at once to the registered display, with an optional blink mask on top.
//   clk      : system clock
//   reset    : synchronous, active-high
//   load     : one-cycle request, accepted only while busy=0
//   value    : hex digits, digit i = value[4i+3:4i], digit 0 rightmost
//   neg      : show minus in the top digit (its nibble is ignored)
//   blank_lz : enable leading-zero blanking
//   blink_en : blink the whole display
//   busy     : scan/commit in progress, load ignored
//   done     : one-cycle pulse in the commit cycle
//   hex_out  : digit i at [7i+6:7i], bit order g..a, active-low

module hex_to_7seg (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (digit)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

module hex_display_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      neg,
  input  logic                      blank_lz,
  input  logic                      blink_en,
  output logic                      busy,
  output logic                      done,
  output logic [7*NUM_DIGITS-1:0]   hex_out
);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = $clog2(BLINK_DIV);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state, state_nx;

  logic [4*NUM_DIGITS-1:0] sh_value;
  logic                    sh_neg;
  logic                    sh_blz;
  logic [IDX_W-1:0]        idx;
  logic                    seen_nz;
  logic [6:0]              staging [NUM_DIGITS];
  logic [6:0]              display [NUM_DIGITS];
  logic [CNT_W-1:0]        blink_cnt;
  logic                    phase;

  logic [3:0] nibble;
  logic [6:0] dec_seg;
  logic [6:0] pattern;
  logic       mark_nz;

  // Compare-based select keeps non-power-of-two digit counts in range.
  always_comb begin
    nibble = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) nibble = sh_value[4*i +: 4];
    end
  end

  hex_to_7seg u_dec (
    .digit (nibble),
    .seg   (dec_seg)
  );

  // Minus does not count as a significant digit, so zeros after it blank.
  always_comb begin
    pattern = dec_seg;
    mark_nz = 1'b1;
    if (sh_neg && idx == LAST) begin
      pattern = 7'h3F;
      mark_nz = 1'b0;
    end else if (sh_blz && !seen_nz && nibble == 4'h0 && idx != '0) begin
      pattern = 7'h7F;
      mark_nz = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (load) state_nx = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (idx == '0) state_nx = COMMIT;
      end
      COMMIT: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_value <= '0;
      sh_neg   <= 1'b0;
      sh_blz   <= 1'b0;
      idx      <= '0;
      seen_nz  <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        staging[i] <= '1;
        display[i] <= '1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            sh_value <= value;
            sh_neg   <= neg;
            sh_blz   <= blank_lz;
            idx      <= LAST;
            seen_nz  <= 1'b0;
          end
        end
        SCAN: begin
          for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) staging[i] <= pattern;
          end
          if (mark_nz) seen_nz <= 1'b1;
          if (idx != '0) idx <= idx - IDX_W'(1);
        end
        COMMIT: begin
          for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            display[i] <= staging[i];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    hex_out = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      hex_out[7*i +: 7] = display[i] | {7{blink_en & phase}};
    end
  end
endmodule

// File: doc/hex_display_scan_ctrl.md
# hex_display_scan_ctrl

Sequencer that shares one 4-bit hex-to-seven-segment decoder among NUM_DIGITS display digits. A multi-digit value is loaded with a one-cycle strobe. The block walks the digits one per clock through the single decoder and applies leading-zero blanking and an optional minus sign. It then commits all patterns at once to registered, active-low segment outputs that drive the board's HEX displays, with an optional blink mask.

## Interface
Parameters:
- NUM_DIGITS, 6, number of display digits (2..8)
- BLINK_DIV, 25000000, clock cycles per blink half-period (≥2)

Ports:
- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high reset
- load  in  1  one-cycle request to display value; accepted only when busy=0
- value  in  4*NUM_DIGITS  hex digits; digit i = value[4i+3:4i], digit 0 rightmost
- neg  in  1  show minus sign in digit NUM_DIGITS-1 (its nibble is ignored)
- blank_lz  in  1  enable leading-zero blanking
- blink_en  in  1  enable blinking of the whole display
- busy  out  1  scan in progress; load ignored
- done  out  1  one-cycle pulse when new patterns are committed
- hex_out  out  7*NUM_DIGITS  digit i at [7i+6:7i], bit order g..a, active-low (0 = segment lit)

## Operation
- Instantiates the team's combinational hex-to-seven-segment decoder once. The decoder is active-low, with f[0]=segment a through f[6]=segment g. Its input is driven by the nibble currently selected by the scan index.
- Registers:
  - shadow value, neg and blank_lz, captured on load
  - scan index idx
  - seen_nz flag
  - staging pattern array
  - display array
  - blink counter and phase bit
- States:
  - IDLE: busy=0. When load=1, capture the shadow registers, set idx=NUM_DIGITS-1, clear seen_nz, and go to SCAN.
  - SCAN: busy=1. On each edge, write one staging digit at idx, then decrement idx. After writing idx=0, go to COMMIT.
  - COMMIT: busy=1. Copy staging to display, pulse done=1 for this cycle only, and go to IDLE.
- Pattern selection for digit idx, in priority order:
  1. If neg and idx=NUM_DIGITS-1, the pattern is minus, 7'h3F.
  2. Else if blank_lz, seen_nz=0, nibble=0 and idx≠0, the pattern is blank, 7'h7F.
  3. Otherwise the pattern is the decoder output, and seen_nz is set.
  - Digit 0 is never blanked, so a value of zero shows "0".
- Blink:
  - The counter runs 0..BLINK_DIV-1 and wraps.
  - On each wrap the phase bit toggles.
  - The counter is free-running and independent of the scan.
- Output: hex_out = display | {7*NUM_DIGITS{blink_en & phase}}. The mask from blink_en is combinational; everything else is registered.
- Load while busy=1 is dropped, not queued.

## Timing
- Reset values:
  - state IDLE, busy=0, done=0
  - display all ones, so hex_out all ones (blank)
  - staging all ones, blink counter 0, phase 0, idx 0, seen_nz 0
- Load accepted at edge E0. busy=1 from E0. Staging digits are written at E1..E_NUM_DIGITS.
- COMMIT state occupies the cycle after E_NUM_DIGITS: done=1 and busy=1 in that cycle. At the next edge, display/hex_out update and busy/done fall to 0.
- Load-to-new-hex_out latency is NUM_DIGITS+2 edges. busy is high for NUM_DIGITS+1 cycles.
- hex_out holds its previous content during the scan, with no partial updates.
- Reset mid-scan: return to IDLE, display and hex_out go blank, no done pulse.
- reset and load in the same cycle: reset wins and the load is lost.
- A new load may be presented in the cycle after COMMIT. Back-to-back loads give one update per NUM_DIGITS+2 cycles.
- Shadow inputs are sampled only at the load edge. value changes during the scan have no effect.

## Test plan
NUM_DIGITS=4, BLINK_DIV=4 for all scenarios.
1. Reset held 2 cycles, then idle 10 cycles -> hex_out=28'hFFFFFFF, busy=0, done never high.
2. load with value=16'h1A3F, neg=0, blank_lz=0:
   - busy high for exactly 5 cycles, done high for exactly 1 cycle (the 5th).
   - Afterwards digits 3..0 = 7'h79, 7'h08, 7'h30, 7'h0E.
3. Leading-zero blanking with blank_lz=1:
   - value=16'h0005 -> 7'h7F, 7'h7F, 7'h7F, 7'h12.
   - value=16'h0000 -> 7'h7F, 7'h7F, 7'h7F, 7'h40.
   - value=16'h0102 -> 7'h7F, 7'h79, 7'h40, 7'h24.
4. neg=1, blank_lz=1, value=16'hF007 -> 7'h3F, 7'h7F, 7'h7F, 7'h78. The top nibble F is ignored.
5. Disturbances during a scan:
   - load again 2 cycles into the scan -> ignored; only one done pulse, result from the first value.
   - reset 3 cycles into the scan -> hex_out blank, no done pulse, busy=0.
6. Blink after a committed 16'h1234 with blink_en=1 -> hex_out alternates 4 cycles blank (all ones) and 4 cycles patterns 7'h79, 7'h24, 7'h30, 7'h19. With blink_en=0 the patterns are steady.
